// File: rtl/imu_bias_cal.sv
// imu_bias_cal: estimates a static gyro bias per axis by averaging 2^NUM_CAL_LOG2 samples
// after an initial settle period, then streams bias-corrected, saturated gyro data and a
// registered copy of the accel data with a one-cycle valid strobe.
// Optional feature: define IMU_BIAS_DEADBAND_EN to zero corrected gyro values whose
// magnitude is at most DEADBAND.
module imu_bias_cal #(
  parameter int unsigned NUM_CAL_LOG2   = 6,
  parameter int unsigned SETTLE_SAMPLES = 8,
  parameter int unsigned DEADBAND       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic signed [15:0] accel_x_in,
  input  logic signed [15:0] accel_y_in,
  input  logic signed [15:0] accel_z_in,
  input  logic signed [15:0] gyro_x_in,
  input  logic signed [15:0] gyro_y_in,
  input  logic signed [15:0] gyro_z_in,
  input  logic               recal,
  output logic               out_valid,
  output logic signed [15:0] accel_x_out,
  output logic signed [15:0] accel_y_out,
  output logic signed [15:0] accel_z_out,
  output logic signed [15:0] gyro_x_out,
  output logic signed [15:0] gyro_y_out,
  output logic signed [15:0] gyro_z_out,
  output logic               cal_busy,
  output logic               cal_done
);

  localparam int unsigned NumCal = 2 ** NUM_CAL_LOG2;
  localparam int unsigned CntMax = (SETTLE_SAMPLES > NumCal) ? SETTLE_SAMPLES : NumCal;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned AccW   = 16 + NUM_CAL_LOG2;
  localparam int          Db     = int'(DEADBAND);
  // Unused when SETTLE_SAMPLES is 0: the settle phase then ends unconditionally.
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_SAMPLES - 1);
  localparam logic [CntW-1:0] AccumLast  = CntW'(NumCal - 1);

`ifdef IMU_BIAS_DEADBAND_EN
  localparam bit DeadbandEn = 1'b1;
`else
  localparam bit DeadbandEn = 1'b0;
`endif

  typedef enum logic [1:0] {StSettle, StAccum, StRun} state_e;

  state_e r_state;
  state_e w_state_next;

  logic [CntW-1:0]        r_cnt;
  logic signed [AccW-1:0] r_acc  [3];
  logic signed [15:0]     r_bias [3];

  logic signed [15:0]     w_gyro [3];
  logic signed [15:0]     w_accel[3];
  logic signed [AccW-1:0] w_sum  [3];
  logic signed [16:0]     w_diff [3];
  logic signed [15:0]     w_corr [3];
  logic signed [15:0]     r_gyro_out [3];
  logic signed [15:0]     r_accel_out[3];
  logic                   r_out_valid;

  logic w_sample;
  logic w_settle_end;
  logic w_accum_end;

  // Zero corrected values inside the deadband when the feature is built in.
  function automatic logic signed [15:0] f_deadband(input logic signed [15:0] v);
    int vi;
    vi = int'(v);
    if (DeadbandEn && (vi <= Db) && (vi >= -Db)) begin
      return '0;
    end
    return v;
  endfunction

  assign w_gyro[0]  = gyro_x_in;
  assign w_gyro[1]  = gyro_y_in;
  assign w_gyro[2]  = gyro_z_in;
  assign w_accel[0] = accel_x_in;
  assign w_accel[1] = accel_y_in;
  assign w_accel[2] = accel_z_in;

  // recal wins over a coincident strobe, so such a sample is never consumed.
  assign w_sample     = in_valid & ~recal;
  assign w_settle_end = (SETTLE_SAMPLES == 0) || (w_sample && (r_cnt == SettleLast));
  assign w_accum_end  = w_sample && (r_cnt == AccumLast);

  // Per-axis accumulate, average and saturating bias correction.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_sum[i]  = r_acc[i] + $signed({{NUM_CAL_LOG2{w_gyro[i][15]}}, w_gyro[i]});
      w_diff[i] = $signed({w_gyro[i][15], w_gyro[i]}) - $signed({r_bias[i][15], r_bias[i]});
      if (w_diff[i][16] != w_diff[i][15]) begin
        w_corr[i] = w_diff[i][16] ? 16'sh8000 : 16'sh7fff;
      end else begin
        w_corr[i] = w_diff[i][15:0];
      end
      w_corr[i] = f_deadband(w_corr[i]);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StSettle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; recal restarts calibration from any state.
  always_comb begin
    w_state_next = r_state;
    if (recal) begin
      w_state_next = StSettle;
    end else begin
      unique case (r_state)
        StSettle: if (w_settle_end) w_state_next = StAccum;
        StAccum:  if (w_accum_end) w_state_next = StRun;
        StRun:    w_state_next = StRun;
        default:  w_state_next = StSettle;
      endcase
    end
  end

  // Status outputs decoded from the state.
  always_comb begin
    cal_busy = 1'b1;
    cal_done = 1'b0;
    unique case (r_state)
      StRun:   begin cal_busy = 1'b0; cal_done = 1'b1; end
      default: begin cal_busy = 1'b1; cal_done = 1'b0; end
    endcase
  end

  // Sample counter, accumulators and latched bias.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      for (int i = 0; i < 3; i++) begin
        r_acc[i]  <= '0;
        r_bias[i] <= '0;
      end
    end else if (recal) begin
      // Bias survives a recal until the next accumulation completes.
      r_cnt <= '0;
      for (int i = 0; i < 3; i++) r_acc[i] <= '0;
    end else begin
      unique case (r_state)
        StSettle: begin
          if (w_settle_end) begin
            r_cnt <= '0;
          end else if (w_sample) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StAccum: begin
          if (w_accum_end) begin
            r_cnt <= '0;
            for (int i = 0; i < 3; i++) begin
              r_acc[i]  <= '0;
              // Upper bits of the full sum are the floor of the average.
              r_bias[i] <= w_sum[i][AccW-1:NUM_CAL_LOG2];
            end
          end else if (w_sample) begin
            r_cnt <= r_cnt + 1'b1;
            for (int i = 0; i < 3; i++) r_acc[i] <= w_sum[i];
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Output registers: updated only on accepted samples in the run state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_gyro_out[i]  <= '0;
        r_accel_out[i] <= '0;
      end
    end else begin
      r_out_valid <= w_sample && (r_state == StRun);
      if (w_sample && (r_state == StRun)) begin
        for (int i = 0; i < 3; i++) begin
          r_gyro_out[i]  <= w_corr[i];
          r_accel_out[i] <= w_accel[i];
        end
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign accel_x_out = r_accel_out[0];
  assign accel_y_out = r_accel_out[1];
  assign accel_z_out = r_accel_out[2];
  assign gyro_x_out  = r_gyro_out[0];
  assign gyro_y_out  = r_gyro_out[1];
  assign gyro_z_out  = r_gyro_out[2];

endmodule
